// File: rtl/encode_instr_stream_pkg.sv
// Shared constants and types for the x86 instruction-stream encoder and its decoder checker.
package encode_instr_stream_pkg;

    localparam logic [7:0] PFX_OPSIZE   = 8'h66;
    localparam logic [7:0] PFX_ADDRSIZE = 8'h67;

    localparam int unsigned WinBytes = 9;
    localparam int unsigned MaxBody  = 11;

    // Operand encoding forms, common to encoder and decoder.
    localparam logic [3:0] OPND_ENC_NONE                = 4'd0;
    localparam logic [3:0] OPND_ENC_IMM                 = 4'd1;
    localparam logic [3:0] OPND_ENC_REG                 = 4'd2;
    localparam logic [3:0] OPND_ENC_REG_IMM             = 4'd3;
    localparam logic [3:0] OPND_ENC_EAX_IMM             = 4'd4;
    localparam logic [3:0] OPND_ENC_EAX_REG             = 4'd5;
    localparam logic [3:0] OPND_ENC_DISP                = 4'd6;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM         = 4'd7;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_IMM     = 4'd8;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG     = 4'd9;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG_IMM = 4'd10;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG_CL  = 4'd11;
    localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM     = 4'd12;
    localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM_IMM = 4'd13;

    // Encoding order is the emission order of the stream.
    typedef enum logic [2:0] {
        EncStIdle    = 3'd0,
        EncStPfxOp   = 3'd1,
        EncStPfxAddr = 3'd2,
        EncStOpc     = 3'd3,
        EncStModrm   = 3'd4,
        EncStSib     = 3'd5,
        EncStDisp    = 3'd6,
        EncStImm     = 3'd7
    } enc_state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [3:0]  form;
        logic [1:0]  modrm_mod;
        logic [2:0]  modrm_reg;
        logic [2:0]  modrm_rm;
        logic [7:0]  sib;
        logic [31:0] disp;
        logic [31:0] imm;
        logic        imm_1byte;
        logic        op16;
        logic        addr16;
    } enc_req_t;

    // First present field strictly after cur; present is indexed by state encoding.
    function automatic enc_state_e next_field(input logic [7:0] present, input enc_state_e cur);
        enc_state_e nxt;
        nxt = EncStIdle;
        for (int i = 7; i >= 0; i--) begin
            if (i > int'(cur) && present[i]) begin
                nxt = enc_state_e'(3'(i));
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/encode_field_lengths.sv
// Field presence and length rules for an x86 instruction body, derived from operand form,
// ModR/M and size prefixes. Purely combinational.
module encode_field_lengths
    import encode_instr_stream_pkg::*;
(
    input  logic [3:0] form_i,
    input  logic [1:0] mod_i,
    input  logic [2:0] rm_i,
    input  logic       op16_i,
    input  logic       addr16_i,
    input  logic       imm_1byte_i,
    output logic       has_modrm_o,
    output logic       has_sib_o,
    output logic [2:0] disp_len_o,
    output logic [2:0] imm_len_o
);

    logic has_imm;

    always_comb begin
        has_modrm_o = 1'b0;
        case (form_i)
            OPND_ENC_MODREGRM_RM,
            OPND_ENC_MODREGRM_RM_IMM,
            OPND_ENC_MODREGRM_RM_REG,
            OPND_ENC_MODREGRM_RM_REG_IMM,
            OPND_ENC_MODREGRM_RM_REG_CL,
            OPND_ENC_MODREGRM_REG_RM,
            OPND_ENC_MODREGRM_REG_RM_IMM: has_modrm_o = 1'b1;
            default: has_modrm_o = 1'b0;
        endcase
    end

    always_comb begin
        has_imm = 1'b0;
        case (form_i)
            OPND_ENC_IMM,
            OPND_ENC_MODREGRM_RM_IMM,
            OPND_ENC_REG_IMM,
            OPND_ENC_EAX_IMM,
            OPND_ENC_MODREGRM_REG_RM_IMM,
            OPND_ENC_MODREGRM_RM_REG_IMM: has_imm = 1'b1;
            default: has_imm = 1'b0;
        endcase
    end

    // 16-bit addressing has no SIB byte, and its no-base form is rm=110 rather than rm=101.
    assign has_sib_o = has_modrm_o && !addr16_i && (mod_i != 2'b11) && (rm_i == 3'b100);

    always_comb begin
        disp_len_o = 3'd0;
        if (has_modrm_o && mod_i == 2'b01) begin
            disp_len_o = 3'd1;
        end else if ((has_modrm_o && (mod_i == 2'b10 ||
                     (mod_i == 2'b00 && rm_i == (addr16_i ? 3'b110 : 3'b101)))) ||
                     form_i == OPND_ENC_DISP) begin
            disp_len_o = addr16_i ? 3'd2 : 3'd4;
        end
    end

    always_comb begin
        imm_len_o = 3'd0;
        if (has_imm) begin
            if (imm_1byte_i) begin
                imm_len_o = 3'd1;
            end else if (op16_i) begin
                imm_len_o = 3'd2;
            end else begin
                imm_len_o = 3'd4;
            end
        end
    end

endmodule

// File: rtl/encode_instr_stream.sv
// Serialises an x86 instruction request into a byte stream, one byte per beat, and packs
// the prefix-stripped instruction window consumed by the decoder.
module encode_instr_stream
    import encode_instr_stream_pkg::*;
#(
    parameter bit EMIT_PREFIXES = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_opcode,
    input  logic [3:0]  req_opnd_form,
    input  logic [1:0]  req_mod,
    input  logic [2:0]  req_reg,
    input  logic [2:0]  req_rm,
    input  logic [7:0]  req_sib,
    input  logic [31:0] req_disp,
    input  logic [31:0] req_imm,
    input  logic        req_imm_1byte,
    input  logic        req_pfx_op16,
    input  logic        req_pfx_addr16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [71:0] out_win,
    output logic [3:0]  out_win_len,
    output logic        win_overflow
);

    enc_state_e  state_q, state_d;
    enc_req_t    req_q, req_d, req_in;
    logic [2:0]  cnt_q, cnt_d;
    logic [71:0] win_q, win_d;
    logic [3:0]  win_len_q, win_len_d;
    logic        win_ovf_q, win_ovf_d;

    logic        idle, accept, beat;
    logic [3:0]  len_form;
    logic [1:0]  len_mod;
    logic [2:0]  len_rm;
    logic        len_op16, len_addr16, len_imm_1byte;
    logic        has_modrm, has_sib;
    logic [2:0]  disp_len, imm_len;
    logic [7:0]  present;
    enc_state_e  nxt_state;
    logic        field_done;
    logic        body_byte;
    logic [7:0]  opc_byte;

    assign req_in = '{
        opcode:    req_opcode,
        form:      req_opnd_form,
        modrm_mod: req_mod,
        modrm_reg: req_reg,
        modrm_rm:  req_rm,
        sib:       req_sib,
        disp:      req_disp,
        imm:       req_imm,
        imm_1byte: req_imm_1byte,
        op16:      req_pfx_op16,
        addr16:    req_pfx_addr16
    };

    assign idle   = (state_q == EncStIdle);
    assign accept = req_valid && idle;
    assign beat   = out_valid && out_ready;

    // In IDLE the lengths come straight from the ports so the first byte is ready next cycle.
    assign len_form      = idle ? req_opnd_form  : req_q.form;
    assign len_mod       = idle ? req_mod        : req_q.modrm_mod;
    assign len_rm        = idle ? req_rm         : req_q.modrm_rm;
    assign len_op16      = idle ? req_pfx_op16   : req_q.op16;
    assign len_addr16    = idle ? req_pfx_addr16 : req_q.addr16;
    assign len_imm_1byte = idle ? req_imm_1byte  : req_q.imm_1byte;

    encode_field_lengths u_field_lengths (
        .form_i      (len_form),
        .mod_i       (len_mod),
        .rm_i        (len_rm),
        .op16_i      (len_op16),
        .addr16_i    (len_addr16),
        .imm_1byte_i (len_imm_1byte),
        .has_modrm_o (has_modrm),
        .has_sib_o   (has_sib),
        .disp_len_o  (disp_len),
        .imm_len_o   (imm_len)
    );

    // Bit order follows the state encoding: IMM, DISP, SIB, MODRM, OPC, PFX_ADDR, PFX_OP, IDLE.
    assign present = {imm_len != 3'd0, disp_len != 3'd0, has_sib, has_modrm, 1'b1,
                      EMIT_PREFIXES && len_addr16, EMIT_PREFIXES && len_op16, 1'b0};

    assign nxt_state = next_field(present, state_q);

    always_comb begin
        field_done = 1'b1;
        unique case (state_q)
            EncStDisp: field_done = (cnt_q == disp_len - 3'd1);
            EncStImm:  field_done = (cnt_q == imm_len - 3'd1);
            default:   field_done = 1'b1;
        endcase
    end

    always_comb begin
        opc_byte = req_q.opcode;
        if (req_q.form == OPND_ENC_REG || req_q.form == OPND_ENC_REG_IMM) begin
            opc_byte[2:0] = req_q.opcode[2:0] | req_q.modrm_reg;
        end else if (req_q.form == OPND_ENC_EAX_REG) begin
            opc_byte[2:0] = req_q.opcode[2:0] | req_q.modrm_rm;
        end
    end

    always_comb begin
        out_byte = 8'h00;
        unique case (state_q)
            EncStIdle:    out_byte = 8'h00;
            EncStPfxOp:   out_byte = PFX_OPSIZE;
            EncStPfxAddr: out_byte = PFX_ADDRSIZE;
            EncStOpc:     out_byte = opc_byte;
            EncStModrm:   out_byte = {req_q.modrm_mod, req_q.modrm_reg, req_q.modrm_rm};
            EncStSib:     out_byte = req_q.sib;
            EncStDisp: begin
                for (int i = 0; i < 4; i++) begin
                    if (cnt_q == 3'(i)) out_byte = req_q.disp[i*8 +: 8];
                end
            end
            EncStImm: begin
                for (int i = 0; i < 4; i++) begin
                    if (cnt_q == 3'(i)) out_byte = req_q.imm[i*8 +: 8];
                end
            end
            default:      out_byte = 8'h00;
        endcase
    end

    assign req_ready = idle;
    assign out_valid = !idle;
    assign out_last  = !idle && field_done && (nxt_state == EncStIdle);
    assign body_byte = (state_q != EncStPfxOp) && (state_q != EncStPfxAddr);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        win_len_d = win_len_q;
        win_ovf_d = win_ovf_q;
        if (accept) begin
            state_d   = nxt_state;
            req_d     = req_in;
            cnt_d     = 3'd0;
            win_d     = '0;
            win_len_d = 4'd0;
            win_ovf_d = 1'b0;
        end else if (beat) begin
            if (field_done) begin
                state_d = nxt_state;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
            if (body_byte) begin
                for (int i = 0; i < int'(WinBytes); i++) begin
                    if (win_len_q == 4'(i)) win_d[i*8 +: 8] = out_byte;
                end
                if (win_len_q >= 4'(WinBytes)) win_ovf_d = 1'b1;
                if (win_len_q < 4'(MaxBody)) win_len_d = win_len_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EncStIdle;
            req_q     <= '0;
            cnt_q     <= 3'd0;
            win_q     <= '0;
            win_len_q <= 4'd0;
            win_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            win_len_q <= win_len_d;
            win_ovf_q <= win_ovf_d;
        end
    end

    assign out_win      = win_q;
    assign out_win_len  = win_len_q;
    assign win_overflow = win_ovf_q;

endmodule

// File: tb/tb_encode_instr_stream.sv
// Directed bench for encode_instr_stream: byte-list reference model plus literal expectations.
module tb_encode_instr_stream;
    import encode_instr_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_opcode = '0;
    logic [3:0]  req_opnd_form = '0;
    logic [1:0]  req_mod = '0;
    logic [2:0]  req_reg = '0;
    logic [2:0]  req_rm = '0;
    logic [7:0]  req_sib = '0;
    logic [31:0] req_disp = '0;
    logic [31:0] req_imm = '0;
    logic        req_imm_1byte = 1'b0;
    logic        req_pfx_op16 = 1'b0;
    logic        req_pfx_addr16 = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [71:0] out_win;
    logic [3:0]  out_win_len;
    logic        win_overflow;

    encode_instr_stream #(.EMIT_PREFIXES(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_opnd_form  (req_opnd_form),
        .req_mod        (req_mod),
        .req_reg        (req_reg),
        .req_rm         (req_rm),
        .req_sib        (req_sib),
        .req_disp       (req_disp),
        .req_imm        (req_imm),
        .req_imm_1byte  (req_imm_1byte),
        .req_pfx_op16   (req_pfx_op16),
        .req_pfx_addr16 (req_pfx_addr16),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_byte       (out_byte),
        .out_last       (out_last),
        .out_win        (out_win),
        .out_win_len    (out_win_len),
        .win_overflow   (win_overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [71:0] exp_win;
    logic [3:0]  exp_len;
    logic        exp_ovf;
    int          exp_n;
    bit          frame_active = 1'b0;
    bit          toggle_mode = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_byte = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [103:0] got_vec();
        logic [103:0] v;
        v = '0;
        for (int i = 0; i < got_q.size() && i < 13; i++) v[i*8 +: 8] = got_q[i];
        return v;
    endfunction

    // Reference model: build the stream as a list of bytes straight from the field rules.
    task automatic model(input logic [7:0] opc, input logic [3:0] form, input logic [1:0] md,
                         input logic [2:0] rg, input logic [2:0] rmv, input logic [7:0] sib,
                         input logic [31:0] disp, input logic [31:0] imm, input logic i1,
                         input logic op16, input logic a16);
        logic [7:0] body[$];
        logic [7:0] o;
        bit hm, hi;
        int dl, il;
        hm = form inside {OPND_ENC_MODREGRM_RM, OPND_ENC_MODREGRM_RM_IMM, OPND_ENC_MODREGRM_RM_REG,
                          OPND_ENC_MODREGRM_RM_REG_IMM, OPND_ENC_MODREGRM_RM_REG_CL,
                          OPND_ENC_MODREGRM_REG_RM, OPND_ENC_MODREGRM_REG_RM_IMM};
        hi = form inside {OPND_ENC_IMM, OPND_ENC_MODREGRM_RM_IMM, OPND_ENC_REG_IMM, OPND_ENC_EAX_IMM,
                          OPND_ENC_MODREGRM_REG_RM_IMM, OPND_ENC_MODREGRM_RM_REG_IMM};
        o = opc;
        if (form == OPND_ENC_REG || form == OPND_ENC_REG_IMM) o[2:0] = o[2:0] | rg;
        if (form == OPND_ENC_EAX_REG) o[2:0] = o[2:0] | rmv;
        body.push_back(o);
        if (hm) body.push_back({md, rg, rmv});
        if (hm && !a16 && md != 2'b11 && rmv == 3'b100) body.push_back(sib);
        dl = 0;
        if (hm && md == 2'b01) dl = 1;
        else if ((hm && (md == 2'b10 || (md == 2'b00 && rmv == (a16 ? 3'd6 : 3'd5)))) ||
                 form == OPND_ENC_DISP) dl = a16 ? 2 : 4;
        for (int i = 0; i < dl; i++) body.push_back(disp[i*8 +: 8]);
        il = hi ? (i1 ? 1 : (op16 ? 2 : 4)) : 0;
        for (int i = 0; i < il; i++) body.push_back(imm[i*8 +: 8]);
        exp_q.delete();
        if (op16) exp_q.push_back(8'h66);
        if (a16) exp_q.push_back(8'h67);
        foreach (body[i]) exp_q.push_back(body[i]);
        exp_win = '0;
        for (int i = 0; i < body.size() && i < 9; i++) exp_win[i*8 +: 8] = body[i];
        exp_len = 4'(body.size() > 11 ? 11 : body.size());
        exp_ovf = body.size() > 9;
        exp_n = exp_q.size();
    endtask

    task automatic send(input logic [7:0] opc, input logic [3:0] form, input logic [1:0] md,
                        input logic [2:0] rg, input logic [2:0] rmv, input logic [7:0] sib,
                        input logic [31:0] disp, input logic [31:0] imm, input logic i1,
                        input logic op16, input logic a16);
        model(opc, form, md, rg, rmv, sib, disp, imm, i1, op16, a16);
        got_q.delete();
        req_opcode = opc; req_opnd_form = form; req_mod = md; req_reg = rg; req_rm = rmv;
        req_sib = sib; req_disp = disp; req_imm = imm; req_imm_1byte = i1;
        req_pfx_op16 = op16; req_pfx_addr16 = a16;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_active = 1'b1;
        // Scramble the request fields: the frame must come from the registered copy.
        req_valid = 1'b0;
        req_opcode = ~opc; req_opnd_form = OPND_ENC_NONE; req_mod = ~md; req_reg = ~rg;
        req_rm = ~rmv; req_sib = ~sib; req_disp = ~disp; req_imm = ~imm;
        req_imm_1byte = ~i1; req_pfx_op16 = ~op16; req_pfx_addr16 = ~a16;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d bytes expected %0d", name, got_q.size(), exp_n);
            exp_q.delete();
        end
        frame_active = 1'b0;
        chk({name, "_count"}, 128'(got_q.size()), 128'(exp_n));
        chk({name, "_win"}, 128'(out_win), 128'(exp_win));
        chk({name, "_win_len"}, 128'(out_win_len), 128'(exp_len));
        chk({name, "_overflow"}, 128'(win_overflow), 128'(exp_ovf));
    endtask

    // Compare process: every cycle with a valid byte is checked against the model queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (prev_stall) begin
                    chk("stall_byte", 128'(out_byte), 128'(prev_byte));
                    chk("stall_last", 128'(out_last), 128'(prev_last));
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected no byte", out_byte);
                end else begin
                    chk("byte", 128'(out_byte), 128'(exp_q[0]));
                    chk("last", 128'(out_last), 128'(exp_q.size() == 1));
                    if (out_ready) begin
                        got_q.push_back(out_byte);
                        void'(exp_q.pop_front());
                    end
                end
                prev_stall = !out_ready;
                prev_byte  = out_byte;
                prev_last  = out_last;
            end else begin
                prev_stall = 1'b0;
            end
            if (rst_n && frame_active && exp_q.size() != 0) begin
                chk("req_ready_low", 128'(req_ready), 128'(1'b0));
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle_mode ? ~out_ready : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #2;
        chk("rst_req_ready", 128'(req_ready), 128'(1'b1));
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_out_last", 128'(out_last), 128'(1'b0));
        chk("rst_out_byte", 128'(out_byte), 128'(8'h00));
        chk("rst_out_win", 128'(out_win), 128'(72'h0));
        chk("rst_win_len", 128'(out_win_len), 128'(4'd0));
        chk("rst_overflow", 128'(win_overflow), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: register-register ADD
        send(8'h01, OPND_ENC_MODREGRM_RM_REG, 2'b11, 3'b011, 3'b000, 8'h00, 32'h0, 32'h0, 0, 0, 0);
        wait_frame("c1");
        chk("c1_stream", 128'(got_vec()), 128'(104'hD801));
        chk("c1_win_lit", 128'(out_win), 128'(72'hD801));
        chk("c1_len_lit", 128'(out_win_len), 128'(4'd2));

        // 2: MOV with SIB, disp8, imm32
        send(8'hC7, OPND_ENC_MODREGRM_RM_IMM, 2'b01, 3'b000, 3'b100, 8'h24, 32'h08, 32'h12345678,
             0, 0, 0);
        wait_frame("c2");
        chk("c2_stream", 128'(got_vec()), 128'(104'h12345678082444C7));
        chk("c2_win_lit", 128'(out_win), 128'(72'h12345678082444C7));
        chk("c2_len_lit", 128'(out_win_len), 128'(4'd8));

        // 3: 16-bit immediate with operand-size prefix
        send(8'h05, OPND_ENC_EAX_IMM, 2'b00, 3'b000, 3'b000, 8'h00, 32'h0, 32'h0000BEEF, 0, 1, 0);
        wait_frame("c3");
        chk("c3_stream", 128'(got_vec()), 128'(104'hBEEF0566));
        chk("c3_win_lit", 128'(out_win), 128'(72'hBEEF05));
        chk("c3_len_lit", 128'(out_win_len), 128'(4'd3));

        // 4: case 2 with backpressure
        toggle_mode = 1'b1;
        send(8'hC7, OPND_ENC_MODREGRM_RM_IMM, 2'b01, 3'b000, 3'b100, 8'h24, 32'h08, 32'h12345678,
             0, 0, 0);
        wait_frame("c4");
        toggle_mode = 1'b0;
        chk("c4_stream", 128'(got_vec()), 128'(104'h12345678082444C7));

        // 5: longest body, window overflow
        send(8'h81, OPND_ENC_MODREGRM_RM_IMM, 2'b10, 3'b000, 3'b100, 8'h24, 32'h11223344,
             32'h55667788, 0, 0, 0);
        wait_frame("c5");
        chk("c5_stream", 128'(got_vec()), 128'(104'h5566778811223344248481));
        chk("c5_win_lit", 128'(out_win), 128'(72'h778811223344248481));
        chk("c5_len_lit", 128'(out_win_len), 128'(4'd11));
        chk("c5_ovf_lit", 128'(win_overflow), 128'(1'b1));

        // 6: async reset after the third byte of case 2
        send(8'hC7, OPND_ENC_MODREGRM_RM_IMM, 2'b01, 3'b000, 3'b100, 8'h24, 32'h08, 32'h12345678,
             0, 0, 0);
        n = 0;
        while (got_q.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL c6_wait: got %0d bytes expected 3", got_q.size());
        end
        @(posedge clk);
        #2;
        chk("c6_mid_len", 128'(out_win_len), 128'(4'd3));
        chk("c6_mid_win", 128'(out_win), 128'(72'h2444C7));
        chk("c6_mid_ovf_clr", 128'(win_overflow), 128'(1'b0));
        rst_n = 1'b0;
        frame_active = 1'b0;
        exp_q.delete();
        #1;
        chk("c6_rst_valid", 128'(out_valid), 128'(1'b0));
        chk("c6_rst_last", 128'(out_last), 128'(1'b0));
        chk("c6_rst_win_len", 128'(out_win_len), 128'(4'd0));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("c6_ready", 128'(req_ready), 128'(1'b1));
        chk("c6_valid", 128'(out_valid), 128'(1'b0));
        send(8'h01, OPND_ENC_MODREGRM_RM_REG, 2'b11, 3'b011, 3'b000, 8'h00, 32'h0, 32'h0, 0, 0, 0);
        wait_frame("c6b");
        chk("c6b_stream", 128'(got_vec()), 128'(104'hD801));

        // 7: register folded into opcode, 8-bit immediate
        send(8'hB8, OPND_ENC_REG_IMM, 2'b00, 3'b001, 3'b000, 8'h00, 32'h0, 32'h12345678, 1, 0, 0);
        wait_frame("c7");
        chk("c7_stream", 128'(got_vec()), 128'(104'h78B9));

        // 8: moffs with 16-bit addressing
        send(8'hA1, OPND_ENC_DISP, 2'b00, 3'b000, 3'b000, 8'h00, 32'h00001234, 32'h0, 0, 0, 1);
        wait_frame("c8");
        chk("c8_stream", 128'(got_vec()), 128'(104'h1234A167));
        chk("c8_win_lit", 128'(out_win), 128'(72'h1234A1));

        // 9: EAX_REG folds rm; 16-bit addressing with mod00 rm110 takes disp16
        send(8'h90, OPND_ENC_EAX_REG, 2'b00, 3'b000, 3'b010, 8'h00, 32'h0, 32'h0, 0, 0, 0);
        wait_frame("c9");
        send(8'h8B, OPND_ENC_MODREGRM_REG_RM, 2'b00, 3'b010, 3'b110, 8'hAA, 32'h0000CAFE, 32'h0,
             0, 1, 1);
        wait_frame("c10");
        chk("c10_stream", 128'(got_vec()), 128'(104'hCAFE168B6766));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
